// File: rtl/opll_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : opll_write_queue
// Purpose  : Buffered, paced CPU-to-OPLL register write front end. CPU writes
//            are captured at full clk rate into a small FIFO and replayed to
//            one of NUM_CHIPS OPLL cores on clkena ticks. Replay honours the
//            YM2413 address and data recovery times.
// Ports    : clk      system clock (OPLL xin)
//            reset    asynchronous, active-high
//            clkena   OPLL clock enable; all replay timing counts these ticks
//            cs_n     CPU chip select, active low
//            we_n     CPU write strobe, active low
//            a        0 = address (register pointer) write, 1 = data write
//            chip     target core
//            d        CPU write data
//            wait_n   low while the FIFO is full
//            wr       per-core data-write strobe (one clkena period long)
//            addr     per-core register pointer, core c on bits [8c+7:8c]
//            data     shared data byte
//            level    (OPLL_WQ_STATUS_EN) current FIFO occupancy
//            ovf      (OPLL_WQ_STATUS_EN) sticky drop-while-full flag
//            ovf_clr  (OPLL_WQ_STATUS_EN) clears ovf; a same-clk drop wins
// Options  : define OPLL_WQ_STATUS_EN to add the level/ovf/ovf_clr ports.
// Revision : 1.0  initial release
// ============================================================================
module opll_write_queue #(
    parameter int NUM_CHIPS = 1,
    parameter int DEPTH     = 4,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   clkena,
    input  logic                                                   cs_n,
    input  logic                                                   we_n,
    input  logic                                                   a,
    input  logic [((NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1)-1:0]   chip,
    input  logic [7:0]                                             d,
    output logic                                                   wait_n,
    output logic [NUM_CHIPS-1:0]                                   wr,
    output logic [8*NUM_CHIPS-1:0]                                 addr,
    output logic [7:0]                                             data
`ifdef OPLL_WQ_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]                                 level,
    output logic                                                   ovf,
    input  logic                                                   ovf_clr
`endif
);

    localparam int CW   = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int EW   = CW + 9;          // entry = {chip, a, d}
    localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int TW   = (MAXW > 0) ? $clog2(MAXW + 1) : 1;

    localparam logic [PW:0]   FULL_C      = (PW+1)'(DEPTH);
    localparam logic [CW:0]   NUM_CHIPS_C = (CW+1)'(NUM_CHIPS);
    localparam logic [TW-1:0] ADDR_WAIT_C = TW'(ADDR_WAIT);
    localparam logic [TW-1:0] DATA_WAIT_C = TW'(DATA_WAIT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Capture stage
    logic          strobe_q, strobe_d;
    logic          evt_q, evt_d;
    logic [EW-1:0] evt_entry_q, evt_entry_d;

    // FIFO
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          wait_n_q, wait_n_d;

    // Replay
    state_t                 state_q, state_d;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic [NUM_CHIPS-1:0]   wr_q, wr_d;
    logic [8*NUM_CHIPS-1:0] addr_q, addr_d;
    logic [7:0]             data_q, data_d;

    logic          w_strobe;
    logic [CW-1:0] w_evt_chip;
    logic          w_chip_ok;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;
    logic [CW-1:0] w_head_chip;
    logic          w_head_a;
    logic [7:0]    w_head_d;

    // ------------------------------------------------------------------
    // Capture: the strobe is registered once and the write fields are
    // latched alongside the edge flag, so a one-clk CPU strobe is enough.
    // strobe_q resets to "active" so a strobe still held across reset
    // release is not mistaken for a new write.
    // ------------------------------------------------------------------
    always_comb begin
        w_strobe    = ~cs_n & ~we_n;
        strobe_d    = w_strobe;
        evt_d       = w_strobe & ~strobe_q;
        evt_entry_d = {chip, a, d};
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_evt_chip  = evt_entry_q[EW-1:9];
        w_chip_ok   = ({1'b0, w_evt_chip} < NUM_CHIPS_C);
        w_full      = (count_q == FULL_C);
        w_empty     = (count_q == '0);
        w_push      = evt_q & w_chip_ok & ~w_full;
        w_pop       = clkena & (state_q == ST_IDLE) & ~w_empty;
        w_head      = mem_q[rd_ptr_q];
        w_head_chip = w_head[EW-1:9];
        w_head_a    = w_head[8];
        w_head_d    = w_head[7:0];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = evt_entry_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);   // DEPTH is a power of two
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        // Computed from the next count so wait_n tracks the current count.
        wait_n_d = (count_d != FULL_C);
    end

    // ------------------------------------------------------------------
    // Replay FSM: advances only on clkena ticks.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (clkena) begin
            case (state_q)
                ST_IDLE: begin
                    wr_d = '0;
                    if (!w_empty) begin
                        state_d = ST_WAIT;
                        if (w_head_a) begin
                            data_d = w_head_d;
                            cnt_d  = DATA_WAIT_C;
                        end else begin
                            cnt_d  = ADDR_WAIT_C;
                        end
                        for (int c = 0; c < NUM_CHIPS; c++) begin
                            if (w_head_chip == CW'(c)) begin
                                if (w_head_a) begin
                                    wr_d[c] = 1'b1;
                                end else begin
                                    addr_d[8*c +: 8] = w_head_d;
                                end
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // wr drops on the first tick after issue.
                    wr_d = '0;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wr_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q    <= 1'b1;
            evt_q       <= 1'b0;
            evt_entry_q <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_n_q    <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            strobe_q    <= strobe_d;
            evt_q       <= evt_d;
            evt_entry_q <= evt_entry_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_n_q    <= wait_n_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign wait_n = wait_n_q;
    assign wr     = wr_q;
    assign addr   = addr_q;
    assign data   = data_q;

`ifdef OPLL_WQ_STATUS_EN
    // ------------------------------------------------------------------
    // Status: occupancy and sticky overflow. A drop in the same clk as
    // ovf_clr leaves the flag set.
    // ------------------------------------------------------------------
    logic ovf_q, ovf_d;
    logic w_drop;

    always_comb begin
        w_drop = evt_q & w_chip_ok & w_full;
        ovf_d  = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (w_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign level = count_q;
    assign ovf   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_opll_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_opll_write_queue
// Purpose  : Directed self-checking bench for opll_write_queue, built with
//            NUM_CHIPS=3 (so chip=3 is an out-of-range target), DEPTH=4,
//            ADDR_WAIT=12, DATA_WAIT=84 and clkena on every 4th clk.
// Revision : 1.0  initial release
// ============================================================================
module tb_opll_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        clkena = 1'b0;
    logic        cs_n;
    logic        we_n;
    logic        a;
    logic [1:0]  chip;
    logic [7:0]  d;
    logic        wait_n;
    logic [2:0]  wr;
    logic [23:0] addr;
    logic [7:0]  data;
`ifdef OPLL_WQ_STATUS_EN
    logic [2:0]  level;
    logic        ovf;
    logic        ovf_clr;
`endif

    opll_write_queue #(
        .NUM_CHIPS (3),
        .DEPTH     (4),
        .ADDR_WAIT (12),
        .DATA_WAIT (84)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clkena  (clkena),
        .cs_n    (cs_n),
        .we_n    (we_n),
        .a       (a),
        .chip    (chip),
        .d       (d),
        .wait_n  (wait_n),
        .wr      (wr),
        .addr    (addr),
        .data    (data)
`ifdef OPLL_WQ_STATUS_EN
        ,
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    // Monitor / clkena generator state
    int          phase       = 0;
    logic        ena_run     = 1'b0;
    int          ticks       = 0;
    int          n_addr      = 0;
    int          n_data      = 0;
    int          addr_tick   = 0;
    int          data_tick   = 0;
    logic [2:0]  last_wr     = '0;
    logic [7:0]  last_data   = '0;
    int          wr_hi       = 0;
    int          last_wr_len = 0;
    int          wr0_cnt     = 0;
    int          multi_hot   = 0;
    logic [2:0]  wr_prev     = '0;
    logic [23:0] addr_prev   = '0;
    logic [23:0] addr_log [$];

    int n_checks = 0;
    int n_err    = 0;

    // Everything sampled on the falling edge; clkena is set here so it is
    // stable for the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (clkena) ticks++;
            if (wr != 3'b000 && wr_prev == 3'b000) begin
                n_data++;
                last_wr   = wr;
                last_data = data;
                data_tick = ticks;
            end
            if (wr != 3'b000) begin
                wr_hi++;
            end else if (wr_prev != 3'b000) begin
                last_wr_len = wr_hi;
                wr_hi       = 0;
            end
            if (wr[0]) wr0_cnt++;
            if (!$onehot0(wr)) multi_hot++;
            if (addr != addr_prev) begin
                n_addr++;
                addr_tick = ticks;
                addr_log.push_back(addr);
            end
            wr_prev   = wr;
            addr_prev = addr;
            phase     = (phase + 1) % 4;
            clkena    = ena_run && (phase == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Bounded waits; an expired bound shows up in the check that follows.
    task automatic wait_addr(input int target);
        int k = 0;
        while (n_addr < target && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    task automatic wait_data(input int target);
        int k = 0;
        while (n_data < target && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    // One-clk strobe, then idle so that successive strobes are gap clks apart.
    task automatic cpu_write(input logic [1:0] c, input logic aa, input logic [7:0] dd, input int gap);
        chip = c;
        a    = aa;
        d    = dd;
        cs_n = 1'b0;
        we_n = 1'b0;
        wait_clks(1);
        cs_n = 1'b1;
        we_n = 1'b1;
        wait_clks(gap - 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_a;
        int base_d;
        int base_l;
        int base_w0;

        reset = 1'b1;
        cs_n  = 1'b1;
        we_n  = 1'b1;
        a     = 1'b0;
        chip  = 2'd0;
        d     = 8'h00;
`ifdef OPLL_WQ_STATUS_EN
        ovf_clr = 1'b0;
`endif
        wait_clks(3);

        // ---------------- Reset state ----------------
        check("reset_wait_n", 32'(wait_n), 32'h1);
        check("reset_wr",     32'(wr),     32'h0);
        check("reset_addr",   32'(addr),   32'h0);
        check("reset_data",   32'(data),   32'h0);
`ifdef OPLL_WQ_STATUS_EN
        check("reset_level",  32'(level),  32'h0);
        check("reset_ovf",    32'(ovf),    32'h0);
`endif
        reset   = 1'b0;
        ena_run = 1'b1;
        wait_clks(2);

        // ---------------- Address then data, chip 0 ----------------
        base_a = n_addr;
        base_d = n_data;
        cpu_write(2'd0, 1'b0, 8'h10, 4);
        cpu_write(2'd0, 1'b1, 8'h55, 4);
        wait_data(base_d + 1);
        check("t1_addr_issues", 32'(n_addr - base_a), 32'd1);
        check("t1_addr0",       32'(addr[7:0]),       32'h10);
        check("t1_data_issues", 32'(n_data - base_d), 32'd1);
        check("t1_spacing",     32'(data_tick - addr_tick), 32'd14);
        check("t1_wr",          32'(last_wr),         32'h1);
        check("t1_data",        32'(last_data),       32'h55);
        wait_clks(8);
        check("t1_wr_len_clks", 32'(last_wr_len),     32'd4);
        wait_clks(4 * 90);

        // ---------------- Burst of 5 with nothing drained ----------------
        ena_run = 1'b0;
        base_l  = addr_log.size();
        for (int i = 1; i <= 5; i++) begin
            cpu_write(2'd0, 1'b0, 8'(i), 2);
        end
        check("t2_wait_n_full", 32'(wait_n), 32'h0);
`ifdef OPLL_WQ_STATUS_EN
        check("t2_level_full",  32'(level),  32'd4);
        check("t2_ovf_set",     32'(ovf),    32'h1);
        ovf_clr = 1'b1;
        wait_clks(1);
        ovf_clr = 1'b0;
        check("t2_ovf_clr",     32'(ovf),    32'h0);
`endif
        ena_run = 1'b1;
        wait_addr(n_addr + 4);
        wait_clks(4 * 30);
        check("t2_issues",      32'(addr_log.size() - base_l), 32'd4);
        check("t2_wait_n_free", 32'(wait_n), 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (base_l + i < addr_log.size()) begin
                check($sformatf("t2_order%0d", i), 32'(addr_log[base_l + i][7:0]), 32'(i + 1));
            end else begin
                check($sformatf("t2_order%0d", i), 32'hFFFF_FFFF, 32'(i + 1));
            end
        end

        // ---------------- Held strobe and out-of-range chip ----------------
        ena_run = 1'b0;
        base_a  = n_addr;
        chip = 2'd0; a = 1'b0; d = 8'h66;
        cs_n = 1'b0; we_n = 1'b0;
        wait_clks(20);
        cs_n = 1'b1; we_n = 1'b1;
        wait_clks(2);
`ifdef OPLL_WQ_STATUS_EN
        check("t3_level_held", 32'(level), 32'd1);
`endif
        ena_run = 1'b1;
        wait_addr(base_a + 1);
        wait_clks(4 * 20);
        check("t3_held_issues", 32'(n_addr - base_a), 32'd1);
        check("t3_held_addr",   32'(addr[7:0]),       32'h66);

        ena_run = 1'b0;
        base_a  = n_addr;
        base_d  = n_data;
        cpu_write(2'd3, 1'b1, 8'h77, 3);
        cpu_write(2'd3, 1'b0, 8'h78, 3);
`ifdef OPLL_WQ_STATUS_EN
        check("t3_bad_chip_level", 32'(level), 32'd0);
`endif
        ena_run = 1'b1;
        wait_clks(4 * 20);
        check("t3_bad_chip_data_issues", 32'(n_data - base_d), 32'd0);
        check("t3_bad_chip_addr_issues", 32'(n_addr - base_a), 32'd0);
        check("t3_bad_chip_data",        32'(data),            32'h55);

        // ---------------- Multi-core pointers ----------------
        base_d  = n_data;
        base_w0 = wr0_cnt;
        cpu_write(2'd0, 1'b0, 8'h20, 4);
        cpu_write(2'd1, 1'b0, 8'h30, 4);
        cpu_write(2'd1, 1'b1, 8'hAA, 4);
        wait_data(base_d + 1);
        check("t4_wr",         32'(last_wr),          32'h2);
        check("t4_data",       32'(last_data),        32'hAA);
        check("t4_addr_chip0", 32'(addr[7:0]),        32'h20);
        check("t4_addr_chip1", 32'(addr[15:8]),       32'h30);
        check("t4_addr_chip2", 32'(addr[23:16]),      32'h00);
        wait_clks(4 * 90);
        check("t4_wr0_never",  32'(wr0_cnt - base_w0), 32'd0);

        // ---------------- Push and pop in the same clk, level 2 ----------------
        ena_run = 1'b0;
        base_l  = addr_log.size();
        cpu_write(2'd2, 1'b0, 8'h41, 2);
        cpu_write(2'd2, 1'b0, 8'h42, 2);
        do begin
            @(negedge clk);
            #1;
        end while (phase != 3);
        // Strobe edge registered at the next rising edge; the push lands on
        // the one after, which is the first clkena tick.
        ena_run = 1'b1;
        chip = 2'd2; a = 1'b0; d = 8'h43;
        cs_n = 1'b0; we_n = 1'b0;
        wait_clks(1);
        cs_n = 1'b1; we_n = 1'b1;
        wait_clks(1);
`ifdef OPLL_WQ_STATUS_EN
        check("t5_level_same", 32'(level), 32'd2);
`endif
        check("t5_first_pop", 32'(addr[23:16]), 32'h41);
        wait_addr(n_addr + 2);
        wait_clks(4);
        for (int i = 0; i < 3; i++) begin
            if (base_l + i < addr_log.size()) begin
                check($sformatf("t5_order%0d", i), 32'(addr_log[base_l + i][23:16]), 32'(8'h41 + i));
            end else begin
                check($sformatf("t5_order%0d", i), 32'hFFFF_FFFF, 32'(8'h41 + i));
            end
        end
        wait_clks(4 * 20);

        // ---------------- Reset during WAIT with 3 queued ----------------
        ena_run = 1'b0;
        base_d  = n_data;
        cpu_write(2'd1, 1'b1, 8'hB1, 2);
        cpu_write(2'd0, 1'b0, 8'h71, 2);
        cpu_write(2'd0, 1'b0, 8'h72, 2);
        cpu_write(2'd0, 1'b0, 8'h73, 2);
        check("t6_wait_n_full", 32'(wait_n), 32'h0);
        ena_run = 1'b1;
        wait_data(base_d + 1);
        check("t6_wr_before", 32'(wr), 32'h2);
`ifdef OPLL_WQ_STATUS_EN
        check("t6_level_before", 32'(level), 32'd3);
`endif
        reset = 1'b1;
        chip = 2'd0; a = 1'b0; d = 8'h99;
        cs_n = 1'b0; we_n = 1'b0;
        #1;
        check("t6_rst_wr",     32'(wr),     32'h0);
        check("t6_rst_addr",   32'(addr),   32'h0);
        check("t6_rst_data",   32'(data),   32'h0);
        check("t6_rst_wait_n", 32'(wait_n), 32'h1);
`ifdef OPLL_WQ_STATUS_EN
        check("t6_rst_level",  32'(level),  32'd0);
`endif
        wait_clks(3);
        reset = 1'b0;
        wait_clks(10);
        cs_n = 1'b1; we_n = 1'b1;
        wait_clks(2);
        base_a = n_addr;
        base_d = n_data;
        wait_clks(4 * 30);
        check("t6_no_addr_issue", 32'(n_addr - base_a), 32'd0);
        check("t6_no_data_issue", 32'(n_data - base_d), 32'd0);
        check("t6_addr_still0",   32'(addr),            32'h0);
        cpu_write(2'd0, 1'b0, 8'h5A, 2);
        wait_addr(base_a + 1);
        check("t6_new_write", 32'(addr[7:0]), 32'h5A);

        check("onehot_wr", 32'(multi_hot), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
